// File: rtl/spi_dac_receiver.sv
// spi_dac_receiver
//   Receive side of the SPI link to an LTC2624-style quad DAC. Frames are
//   captured on spi_sck/spi_mosi while dac_cs is low. Each frame is decoded into
//   command, address and data fields, and the block holds an input code and a
//   live code for each of the four channels. All logic runs in the clk domain.
//   The SPI pins are oversampled, so clk must be at least 4x spi_sck.
//
//   Frame layout, MSB first:
//     8 pad | 4 cmd | 4 addr | DATA_W data | 4 pad   (FRAME_W = DATA_W + 20)
//
//   Ports
//     clk, rst            system clock; asynchronous active-low reset
//     spi_sck/mosi        SPI clock (idle low) and data, sampled on sck rise
//     dac_cs              active-low frame select
//     dac_clr             active-low level clear of all channel codes
//     spi_miso            echo of the previous frame (0 without SPI_RX_ECHO_EN)
//     frame_valid         1-cycle pulse, a good frame was decoded
//     frame_err           1-cycle pulse, the frame bit count was not FRAME_W
//     cmd/addr/data       fields of the last good frame
//     dac_code            live codes; ch0 in the low slice, ch3 in the top slice
//
//   Option macro SPI_RX_ECHO_EN
//     When defined, the frame received last (good or bad) is shifted back out
//     on spi_miso during the next frame, MSB first.
//
//   Latency: frame_valid and dac_code change 4 clk after cs rises at the pin.
//   This is 2 synchroniser flops, 1 edge-detect flop, and the DONE state.
module spi_dac_receiver #(
  parameter int DATA_W  = 12,
  parameter int FRAME_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  dac_cs,
  input  logic                  dac_clr,
  output logic                  spi_miso,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [3:0]            cmd,
  output logic [3:0]            addr,
  output logic [DATA_W-1:0]     data,
  output logic [4*DATA_W-1:0]   dac_code
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Synchronisers. sck and cs have a third flop for edge detection.
  // Reset values are the idle levels of the lines.
  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q, clr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
      clr_q  <= 2'b11;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[1:0], dac_cs};
      mosi_q <= {mosi_q[0], spi_mosi};
      clr_q  <= {clr_q[0], dac_clr};
    end
  end

  logic sck_rise, cs_fall, cs_rise, clr_on;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign clr_on   = ~clr_q[1];

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-1:0]  sr;

  logic [3:0]          f_cmd, f_addr;
  logic [DATA_W-1:0]   f_data;
  logic                good;
  assign f_cmd  = sr[DATA_W+11 -: 4];
  assign f_addr = sr[DATA_W+7 -: 4];
  assign f_data = sr[DATA_W+3 : 4];
  assign good   = (state == DONE) && (cnt == CNT_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      cmd         <= '0;
      addr        <= '0;
      data        <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          state <= SHIFT;
          cnt   <= '0;
          sr    <= '0;
        end
        SHIFT: begin
          if (sck_rise) begin
            sr <= {sr[FRAME_W-2:0], mosi_q[1]};
            // The counter saturates, so an over-long frame can never wrap back to FRAME_W.
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
          if (cs_rise) state <= DONE;
        end
        DONE: begin
          if (cnt == CNT_FULL) begin
            frame_valid <= 1'b1;
            cmd         <= f_cmd;
            addr        <= f_addr;
            data        <= f_data;
          end else begin
            frame_err <= 1'b1;
          end
          // A back-to-back cs fall may already be visible here.
          if (cs_fall) begin
            state <= SHIFT;
            cnt   <= '0;
            sr    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-channel input and live registers.
  // A synced clear holds both registers at 0 and overrides a DONE update in the same cycle.
  for (genvar ch = 0; ch < 4; ch++) begin : g_ch
    logic [DATA_W-1:0] in_reg, live_reg;
    logic              sel;
    assign sel = good && ((f_addr == 4'(ch)) || (f_addr == 4'hF));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        in_reg   <= '0;
        live_reg <= '0;
      end else if (clr_on) begin
        in_reg   <= '0;
        live_reg <= '0;
      end else if (sel) begin
        case (f_cmd)
          4'b0000: in_reg <= f_data;
          4'b0001: live_reg <= in_reg;
          4'b0011: begin
            in_reg   <= f_data;
            live_reg <= f_data;
          end
          4'b0100: live_reg <= '0;
          default: ;
        endcase
      end
    end

    assign dac_code[ch*DATA_W +: DATA_W] = live_reg;
  end

`ifdef SPI_RX_ECHO_EN
  // The shift register still holds the previous frame when cs falls.
  // Capture it there, then walk it out MSB first on each sck fall.
  logic [FRAME_W-1:0] echo;
  logic               sck_fall;
  assign sck_fall = ~sck_q[1] & sck_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              echo <= '0;
    else if (cs_fall)                      echo <= sr;
    else if (state == SHIFT && sck_fall)   echo <= {echo[FRAME_W-2:0], 1'b0};
  end

  assign spi_miso = (state == SHIFT) & echo[FRAME_W-1];
`else
  // The pad bits are only needed by the echo path.
  logic unused_pad;
  assign unused_pad = ^{sr[FRAME_W-1:DATA_W+12], sr[3:0]};
  assign spi_miso   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Self-checking bench for spi_dac_receiver with the defaults DATA_W=12 and FRAME_W=32.
// Frames are driven at sck = clk/8. A frame-level model keeps the expected
// channel codes, the last decoded fields and the expected echo.
module tb_spi_dac_receiver;
  logic        clk = 1'b0, rst = 1'b0;
  logic        sck = 1'b0, mosi = 1'b0, cs = 1'b1, clr = 1'b1;
  logic        miso, frame_valid, frame_err;
  logic [3:0]  cmd, addr;
  logic [11:0] data;
  logic [47:0] dac_code;

  spi_dac_receiver #(.DATA_W(12), .FRAME_W(32)) dut (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .dac_cs(cs),
    .dac_clr(clr), .spi_miso(miso), .frame_valid(frame_valid),
    .frame_err(frame_err), .cmd(cmd), .addr(addr), .data(data),
    .dac_code(dac_code)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor
  int cyc = 0, vld_n = 0, err_n = 0, vld_cyc = 0, csr_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin vld_n++; vld_cyc = cyc; end
    if (frame_err === 1'b1) err_n++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model, at frame level
  logic [11:0] m_in [4];
  logic [11:0] m_live [4];
  logic [3:0]  m_cmd, m_addr;
  logic [11:0] m_data;
  logic [31:0] m_last;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_in[i] = '0; m_live[i] = '0; end
    m_cmd = '0; m_addr = '0; m_data = '0; m_last = '0;
  endtask

  function automatic logic [63:0] mk(input logic [3:0] c, input logic [3:0] a,
                                     input logic [11:0] d, input logic [7:0] ph,
                                     input logic [3:0] pl);
    mk = {32'b0, ph, c, a, d, pl};
  endfunction

  task automatic model_frame(input logic [63:0] v, input int n, input bit clr_on);
    if (n == 32) begin
      m_cmd = v[23:20]; m_addr = v[19:16]; m_data = v[15:4];
      for (int ch = 0; ch < 4; ch++)
        if (m_addr == 4'(ch) || m_addr == 4'hF)
          case (m_cmd)
            4'd0: m_in[ch] = m_data;
            4'd1: m_live[ch] = m_in[ch];
            4'd3: begin m_in[ch] = m_data; m_live[ch] = m_data; end
            4'd4: m_live[ch] = '0;
            default: ;
          endcase
    end
    if (clr_on)
      for (int ch = 0; ch < 4; ch++) begin m_in[ch] = '0; m_live[ch] = '0; end
    // The receiver keeps the last 32 bits shifted in.
    if (n >= 32) m_last = v[31:0];
    else         m_last = 32'(v & ((64'd1 << n) - 64'd1));
  endtask

  // Send n bits of v, MSB first, then check the outcome against the model.
  task automatic send_frame(input logic [63:0] v, input int n, input bit use_clr);
    int v0, e0;
    logic [63:0] rx, exp_rx;
    v0 = vld_n; e0 = err_n; rx = '0;
    exp_rx = (n == 0) ? 64'd0 : ({m_last, 32'b0} >> (64 - n));
    cs = 1'b0;
    wait_clk(4);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      wait_clk(4);
      rx = {rx[62:0], miso};
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
    if (use_clr) clr = 1'b0;
    wait_clk(4);
    cs = 1'b1;
    csr_cyc = cyc;
    wait_clk(10);
    clr = 1'b1;
    wait_clk(4);
    model_frame(v, n, use_clr);
    chk("vld_cnt", 64'(vld_n - v0), (n == 32) ? 64'd1 : 64'd0);
    chk("err_cnt", 64'(err_n - e0), (n == 32) ? 64'd0 : 64'd1);
    chk("cmd", 64'(cmd), 64'(m_cmd));
    chk("addr", 64'(addr), 64'(m_addr));
    chk("data", 64'(data), 64'(m_data));
    chk("dac_code", 64'(dac_code), 64'({m_live[3], m_live[2], m_live[1], m_live[0]}));
`ifdef SPI_RX_ECHO_EN
    chk("echo", rx, exp_rx);
`else
    chk("miso0", rx, 64'd0);
`endif
  endtask

  initial begin
    int v0, e0, n;
    logic [3:0] c, a;
    bit cl;
    model_reset();

    // Reset state
    wait_clk(3);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_cmd", 64'(cmd), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_code", 64'(dac_code), 64'd0);
    chk("rst_miso", 64'(miso), 64'd0);
    rst = 1'b1;
    v0 = vld_n; e0 = err_n;
    wait_clk(20);
    chk("rst_nopulse", 64'((vld_n - v0) + (err_n - e0)), 64'd0);

    // Single write+update to channel 2, with a latency check
    send_frame(mk(4'd3, 4'd2, 12'hABC, 8'h00, 4'h0), 32, 1'b0);
    chk("latency", 64'(vld_cyc - csr_cyc), 64'd4);

    // Broadcast input write, then update only channel 0
    send_frame(mk(4'd0, 4'hF, 12'h123, 8'h5A, 4'hC), 32, 1'b0);
    send_frame(mk(4'd1, 4'd0, 12'h777, 8'hFF, 4'hF), 32, 1'b0);

    // Bad lengths and a cs glitch
    send_frame(64'h1_3155_5550 & 64'h7FFF_FFFF, 31, 1'b0);
    send_frame(64'h1_0031_2340, 33, 1'b0);
    send_frame(64'd0, 0, 1'b0);

    // Clear overlapping a write
    send_frame(mk(4'd3, 4'd1, 12'h456, 8'h00, 4'h0), 32, 1'b1);

    // Reset while a frame is in progress
    send_frame(mk(4'd3, 4'hF, 12'hBEE, 8'h00, 4'h0), 32, 1'b0);
    cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 10; i++) begin
      mosi = i[0]; wait_clk(4); sck = 1'b1; wait_clk(4); sck = 1'b0;
    end
    rst = 1'b0; cs = 1'b1; mosi = 1'b0;
    wait_clk(3);
    chk("midrst_code", 64'(dac_code), 64'd0);
    rst = 1'b1;
    v0 = vld_n; e0 = err_n;
    wait_clk(20);
    chk("midrst_nopulse", 64'((vld_n - v0) + (err_n - e0)), 64'd0);
    model_reset();

    // Random frames
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 4))
        0: c = 4'd0; 1: c = 4'd1; 2: c = 4'd3; 3: c = 4'd4;
        default: c = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 3))
        0: a = 4'hF;
        1: a = 4'($urandom_range(0, 15));
        default: a = 4'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 7))
        0: n = 31; 1: n = 33; 2: n = $urandom_range(0, 40);
        default: n = 32;
      endcase
      cl = ($urandom_range(0, 7) == 0);
      send_frame({$urandom(), 32'b0} | mk(c, a, 12'($urandom()), 8'($urandom()), 4'($urandom())),
                 n, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
